// File: rtl/cond_branch_unit.sv
// cond_branch_unit
// Evaluates a 3-bit branch condition against the adder flags (stored, or
// forwarded from the current transaction when it also sets flags), and
// queues resolved branches {taken, pc} in a 2-entry FIFO toward the
// downstream consumer.
// Optional feature: define BRANCH_STATS_EN to add a 16-bit wrapping count
// of taken branches pushed into the FIFO (output taken_cnt).
module cond_branch_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] result,
    input  logic              CF,
    input  logic              OF,
    input  logic              ZF,
    input  logic              SF,
    input  logic              set_flags,
    input  logic              is_branch,
    input  logic [2:0]        cond,
    input  logic [DATA_W-1:0] target,
    input  logic [DATA_W-1:0] pc_seq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic [DATA_W-1:0] out_pc,
`ifdef BRANCH_STATS_EN
    output logic [15:0]       taken_cnt,
`endif
    output logic [3:0]        flags
);

    // Condition decode on flags packed as {CF, OF, ZF, SF}.
    function automatic logic cond_eval(input logic [2:0] c, input logic [3:0] f);
        logic cf, of, zf, sf;
        {cf, of, zf, sf} = f;
        case (c)
            3'b000:  cond_eval = zf;
            3'b001:  cond_eval = ~zf;
            3'b010:  cond_eval = sf ^ of;
            3'b011:  cond_eval = ~(sf ^ of);
            3'b100:  cond_eval = cf;
            3'b101:  cond_eval = ~cf;
            3'b110:  cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // The adder result travels with the transaction but never steers a decision.
    logic result_unused;
    assign result_unused = ^result;

    logic [3:0]        flags_q;
    logic [3:0]        eff_flags_p0;
    logic              taken_p0;
    logic [DATA_W-1:0] pc_p0;
    logic              accept_p0;
    logic              push_p0;
    logic              pop_p0;

    logic [1:0]        count_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic              ent_taken_p1 [2];
    logic [DATA_W-1:0] ent_pc_p1    [2];
    logic              vld_p1;

    // ---- stage p0: decode the incoming transaction ----
    assign accept_p0    = in_valid & in_ready;
    assign eff_flags_p0 = set_flags ? {CF, OF, ZF, SF} : flags_q;
    assign taken_p0     = cond_eval(cond, eff_flags_p0);
    assign pc_p0        = taken_p0 ? target : pc_seq;
    assign push_p0      = accept_p0 & is_branch;
    assign pop_p0       = vld_p1 & out_ready;

    // ---- stage p1: FIFO head toward downstream ----
    assign vld_p1    = (count_q != 2'd0);
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = vld_p1;
    // Head gated by valid so an empty FIFO always presents zeros,
    // which lets the entry storage itself stay unreset.
    assign out_taken = vld_p1 & ent_taken_p1[rd_ptr_q];
    assign out_pc    = vld_p1 ? ent_pc_p1[rd_ptr_q] : '0;
    assign flags     = flags_q;

    // Control state: flag register, FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q  <= 4'b0000;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (accept_p0 && set_flags)
                flags_q <= {CF, OF, ZF, SF};
            if (push_p0)
                wr_ptr_q <= ~wr_ptr_q;
            if (pop_p0)
                rd_ptr_q <= ~rd_ptr_q;
            case ({push_p0, pop_p0})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO entry storage, written at the write pointer on each push.
    always_ff @(posedge clk) begin
        if (push_p0) begin
            ent_taken_p1[wr_ptr_q] <= taken_p0;
            ent_pc_p1[wr_ptr_q]    <= pc_p0;
        end
    end

`ifdef BRANCH_STATS_EN
    // Count taken branches entering the FIFO; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            taken_cnt <= 16'h0000;
        else if (push_p0 && taken_p0)
            taken_cnt <= taken_cnt + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed self-checking bench for cond_branch_unit.
module tb_cond_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] result = 32'h0;
    logic        CF = 1'b0, OF = 1'b0, ZF = 1'b0, SF = 1'b0;
    logic        set_flags = 1'b0;
    logic        is_branch = 1'b0;
    logic [2:0]  cond = 3'b000;
    logic [31:0] target = 32'h0;
    logic [31:0] pc_seq = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_taken;
    logic [31:0] out_pc;
    logic [3:0]  flags;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cond_branch_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .CF        (CF),
        .OF        (OF),
        .ZF        (ZF),
        .SF        (SF),
        .set_flags (set_flags),
        .is_branch (is_branch),
        .cond      (cond),
        .target    (target),
        .pc_seq    (pc_seq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_taken (out_taken),
        .out_pc    (out_pc),
`ifdef BRANCH_STATS_EN
        .taken_cnt (taken_cnt),
`endif
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid  = 1'b0;
        set_flags = 1'b0;
        is_branch = 1'b0;
        cond      = 3'b000;
        {CF, OF, ZF, SF} = 4'b0000;
        target    = 32'h0;
        pc_seq    = 32'h0;
        result    = 32'h0;
    endtask

    task automatic offer(input logic sf_en, input logic [3:0] f, input logic br,
                         input logic [2:0] c, input logic [31:0] tg, input logic [31:0] pc);
        in_valid  = 1'b1;
        set_flags = sf_en;
        {CF, OF, ZF, SF} = f;
        is_branch = br;
        cond      = c;
        target    = tg;
        pc_seq    = pc;
        result    = tg ^ pc;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", flags); end
        n_checks++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL rst_out_taken: got %b expected 0", out_taken); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc: got %h expected 00000000", out_pc); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_eq_taken();
        out_ready = 1'b0;
        offer(1'b1, 4'b0010, 1'b1, 3'b000, 32'h100, 32'h4);
        step();
        drive_idle();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL eq_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_taken !== 1'b1) begin n_fail++; $display("FAIL eq_taken: got %b expected 1", out_taken); end
        n_checks++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL eq_pc: got %h expected 00000100", out_pc); end
        n_checks++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL eq_flags: got %b expected 0010", flags); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL eq_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_signed_cond();
        out_ready = 1'b1;
        // Non-branch flag update: nothing enters the FIFO.
        offer(1'b1, 4'b0001, 1'b0, 3'b110, 32'hDEAD, 32'hBEEF);
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nobranch_valid: got %b expected 0", out_valid); end
        n_checks++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL setflag_flags: got %b expected 0001", flags); end
        // LT on stored SF=1 OF=0; input flags ignored because set_flags=0.
        offer(1'b0, 4'b1110, 1'b1, 3'b010, 32'h200, 32'h8);
        step();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lt_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_taken !== 1'b1) begin n_fail++; $display("FAIL lt_taken: got %b expected 1", out_taken); end
        n_checks++; if (out_pc !== 32'h200) begin n_fail++; $display("FAIL lt_pc: got %h expected 00000200", out_pc); end
        // GE pushed while the LT entry pops: occupancy stays one.
        offer(1'b0, 4'b0000, 1'b1, 3'b011, 32'h300, 32'hC);
        step();
        drive_idle();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ge_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL ge_taken: got %b expected 0", out_taken); end
        n_checks++; if (out_pc !== 32'hC) begin n_fail++; $display("FAIL ge_pc: got %h expected 0000000c", out_pc); end
        n_checks++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL ge_flags_kept: got %b expected 0001", flags); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ge_single_entry: got %b expected 0", out_valid); end
    endtask

    task automatic test_forwarding();
        // Stored SF=1 would make LT taken; forwarded flags (all 0) make it not taken.
        out_ready = 1'b1;
        offer(1'b1, 4'b0000, 1'b1, 3'b010, 32'h40, 32'h44);
        step();
        drive_idle();
        n_checks++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL fwd_taken: got %b expected 0", out_taken); end
        n_checks++; if (out_pc !== 32'h44) begin n_fail++; $display("FAIL fwd_pc: got %h expected 00000044", out_pc); end
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL fwd_flags: got %b expected 0000", flags); end
        step();
    endtask

    task automatic test_cond_table();
        logic [3:0] tf [11];
        logic [2:0] tc [11];
        logic       te [11];
        logic [31:0] exp_pc;
        tf = '{4'b0000, 4'b0010, 4'b0001, 4'b0101, 4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
        tc = '{3'b001,  3'b001,  3'b010,  3'b010,  3'b011,  3'b100,  3'b101,  3'b101,  3'b110,  3'b111,  3'b000};
        te = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            offer(1'b1, tf[i], 1'b1, tc[i], 32'h1000 + i, 32'h2000 + i);
            step();
            drive_idle();
            exp_pc = te[i] ? (32'h1000 + i) : (32'h2000 + i);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cond%0d_valid: got %b expected 1", i, out_valid); end
            n_checks++; if (out_taken !== te[i]) begin n_fail++; $display("FAIL cond%0d_taken: got %b expected %b", i, out_taken, te[i]); end
            n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL cond%0d_pc: got %h expected %h", i, out_pc, exp_pc); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        offer(1'b0, 4'b0000, 1'b1, 3'b110, 32'hA0, 32'hA4);
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_one: got %b expected 1", in_ready); end
        offer(1'b0, 4'b0000, 1'b1, 3'b111, 32'hB0, 32'hB4);
        step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b expected 0", in_ready); end
        offer(1'b0, 4'b0000, 1'b1, 3'b110, 32'hC0, 32'hC4);
        step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_third_blocked: got %b expected 0", in_ready); end
        n_checks++; if (out_pc !== 32'hA0) begin n_fail++; $display("FAIL b2b_hold_pc: got %h expected 000000a0", out_pc); end
        n_checks++; if (out_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_taken: got %b expected 1", out_taken); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_pc !== 32'hB4) begin n_fail++; $display("FAIL b2b_second_pc: got %h expected 000000b4", out_pc); end
        n_checks++; if (out_taken !== 1'b0) begin n_fail++; $display("FAIL b2b_second_taken: got %b expected 0", out_taken); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_pop: got %b expected 1", in_ready); end
        step();
        drive_idle();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_third_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_pc !== 32'hC0) begin n_fail++; $display("FAIL b2b_third_pc: got %h expected 000000c0", out_pc); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        offer(1'b1, 4'b0010, 1'b1, 3'b110, 32'h500, 32'h504);
        step();
        offer(1'b1, 4'b1010, 1'b1, 3'b110, 32'h600, 32'h604);
        step();
        drive_idle();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b expected 0", in_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 1", in_ready); end
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_flags: got %b expected 0000", flags); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pc: got %h expected 00000000", out_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        offer(1'b0, 4'b0000, 1'b1, 3'b110, 32'h700, 32'h704);
        step();
        drive_idle();
        n_checks++; if (out_pc !== 32'h700) begin n_fail++; $display("FAIL mid_after_pc: got %h expected 00000700", out_pc); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discarded: got %b expected 0", out_valid); end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (taken_cnt !== 16'h0) begin n_fail++; $display("FAIL stats_rst: got %h expected 0000", taken_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(1'b0, 4'b0000, 1'b1, 3'b110, 32'h10, 32'h14);
        repeat (65535) step();
        n_checks++; if (taken_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stats_preload: got %h expected ffff", taken_cnt); end
        step();
        n_checks++; if (taken_cnt !== 16'h0000) begin n_fail++; $display("FAIL stats_wrap: got %h expected 0000", taken_cnt); end
        offer(1'b0, 4'b0000, 1'b1, 3'b111, 32'h10, 32'h14);
        step();
        drive_idle();
        n_checks++; if (taken_cnt !== 16'h0000) begin n_fail++; $display("FAIL stats_not_taken: got %h expected 0000", taken_cnt); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_eq_taken();
        test_signed_cond();
        test_forwarding();
        test_cond_table();
        test_back_to_back();
        test_reset_mid();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_branch_unit.md
COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: in_valid  input  1  upstream transaction valid.
REQ-004 SHALL have port: in_ready  output  1  block can accept a transaction.
REQ-005 SHALL have port: result  input  32  adder result (carried, unused for decisions).
REQ-006 SHALL have port: CF, OF, ZF, SF  input  1 each  adder flags; CF=1 means borrow on subtract.
REQ-007 SHALL have port: set_flags  input  1  transaction updates the flag register.
REQ-008 SHALL have port: is_branch  input  1  transaction is a conditional branch.
REQ-009 SHALL have port: cond  input  3  condition code.
REQ-010 SHALL have port: target  input  32  branch target; pc_seq  input  32  fall-through PC.
REQ-011 SHALL have port: out_valid  output  1; out_ready  input  1  downstream handshake.
REQ-012 SHALL have port: out_taken  output  1; out_pc  output  32  resolved branch.
REQ-013 SHALL have port: flags  output  4  stored {CF,OF,ZF,SF}.

Function
REQ-014 Accept = in_valid & in_ready; nothing changes on a non-accepted cycle.
REQ-015 Accepted set_flags=1 SHALL load flag register from inputs at that edge.
REQ-016 Effective flags SHALL be the input flags when set_flags=1, else the stored flags (same-cycle forwarding).
REQ-017 cond SHALL decode on effective flags: 000 EQ ZF; 001 NE ~ZF; 010 LT SF^OF; 011 GE ~(SF^OF); 100 LTU CF; 101 GEU ~CF; 110 ALWAYS 1; 111 NEVER 0.
REQ-018 Accepted is_branch=1 SHALL push {taken, taken ? target : pc_seq} into a 2-entry FIFO; is_branch=0 pushes nothing.
REQ-019 out_valid SHALL equal FIFO non-empty; out_taken/out_pc SHALL show the head entry; pop on out_valid & out_ready.
REQ-020 Latency: entry accepted at edge N SHALL be visible with out_valid=1 after edge N (one cycle), if FIFO was empty.
REQ-021 in_ready SHALL equal FIFO not full, independent of out_ready (no same-cycle pass-through when full).
REQ-022 Simultaneous push and pop with one entry SHALL keep count at one and present the new entry next cycle.
REQ-023 FIFO pointers SHALL be 1-bit and wrap; count range 0..2.
REQ-024 out_pc/out_taken SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-025 rst_n low SHALL immediately clear: FIFO empty, out_valid=0, in_ready=1, flags=4'b0000, out_taken=0, out_pc=0.
REQ-026 Reset mid-operation SHALL discard all buffered entries; first accept after release behaves as from empty.

Configuration
REQ-027 Macro BRANCH_STATS_EN, when defined, SHALL add output taken_cnt (16 bits), reset 0, incrementing on each push with taken=1, wrapping 0xFFFF->0x0000.
REQ-028 Without BRANCH_STATS_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 Reset, then set_flags=1 ZF=1 SF=0 OF=0 CF=0, is_branch=1 cond=000 target=0x100 pc_seq=0x4 -> next cycle out_valid=1, out_taken=1, out_pc=0x100, flags=4'b0010.
REQ-030 Stored flags SF=1 OF=0; set_flags=0, cond=010 then cond=011, out_ready=1 -> out_taken 1 then 0, out_pc=target then pc_seq.
REQ-031 out_ready=0, three branches offered back-to-back -> two accepted, in_ready=0 on third; raise out_ready -> entries emerge in order, third accepted after first pop.
REQ-032 One entry buffered, push and pop same cycle -> out_valid stays 1, count stays 1, new entry at head next cycle.
REQ-033 Reset asserted with two entries buffered -> out_valid=0, in_ready=1, flags=0 immediately, before next clk edge.
REQ-034 With BRANCH_STATS_EN, preload 0xFFFF taken pushes, one more taken -> taken_cnt=0x0000; not-taken push leaves count unchanged.
